// File: rtl/nmi_apb_bridge.sv
// NMI (valid/ready) to APB4 bridge with parametrised address decode,
// decode-miss and PREADY-timeout responses, and a saturating error counter.
module nmi_apb_bridge #(
   parameter int unsigned           NUM_SLV     = 8,
   parameter logic [NUM_SLV*32-1:0] SLV_BASE    = {NUM_SLV{32'h0}},
   parameter logic [NUM_SLV*32-1:0] SLV_MASK    = {NUM_SLV{32'hFFFF_F000}},
   parameter int unsigned           TIMEOUT_CYC = 256,
   parameter logic [31:0]           ERR_RDATA   = 32'hDEAD_BEEF,
   parameter int unsigned           ERR_CNT_W   = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    mem_valid_i,
   input  logic [31:0]             mem_addr_i,
   input  logic [31:0]             mem_wdata_i,
   input  logic [3:0]              mem_wstrb_i,
   output logic [31:0]             mem_rdata_o,
   output logic                    mem_ready_o,
   output logic [31:0]             apb_paddr_o,
   output logic [2:0]              apb_pprot_o,
   output logic [NUM_SLV-1:0]      apb_psel_o,
   output logic                    apb_penable_o,
   output logic                    apb_pwrite_o,
   output logic [31:0]             apb_pwdata_o,
   output logic [3:0]              apb_pstrb_o,
   input  logic [NUM_SLV-1:0]      apb_pready_i,
   input  logic [NUM_SLV*32-1:0]   apb_prdata_i,
   input  logic [NUM_SLV-1:0]      apb_pslverr_i,
   output logic                    err_o,
   output logic [1:0]              err_code_o,
   output logic [ERR_CNT_W-1:0]    err_cnt_o
);

   localparam int unsigned IdxW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

   state_e               state_q, state_d;
   logic [31:0]          addr_q, addr_d;
   logic [31:0]          wdata_q, wdata_d;
   logic [3:0]           wstrb_q, wstrb_d;
   logic                 pwrite_q, pwrite_d;
   logic [IdxW-1:0]      idx_q, idx_d;
   logic [31:0]          rdata_q, rdata_d;
   logic [1:0]           code_q, code_d;
   logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]          tcnt_q, tcnt_d;

   logic                 dec_hit;
   logic [IdxW-1:0]      dec_idx;
   logic                 sel_pready;
   logic                 sel_pslverr;
   logic [31:0]          sel_prdata;
   logic                 err_done;

   // Address decode; scanning downwards lets the lowest hitting index win.
   always_comb begin
      dec_hit = 1'b0;
      dec_idx = '0;
      for (int i = NUM_SLV - 1; i >= 0; i--) begin
         if ((mem_addr_i & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
            dec_hit = 1'b1;
            dec_idx = IdxW'(i);
         end
      end
   end

   // Only the latched slave's response is observed.
   assign sel_pready  = apb_pready_i[idx_q];
   assign sel_pslverr = apb_pslverr_i[idx_q];
   assign sel_prdata  = apb_prdata_i[32*idx_q +: 32];

   // Next-state, captured-response and error-counter logic.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      pwrite_d = pwrite_q;
      idx_d    = idx_q;
      rdata_d  = rdata_q;
      code_d   = code_q;
      cnt_d    = cnt_q;
      tcnt_d   = tcnt_q;
      err_done = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (mem_valid_i) begin
               addr_d   = mem_addr_i;
               wdata_d  = mem_wdata_i;
               wstrb_d  = mem_wstrb_i;
               pwrite_d = |mem_wstrb_i;
               idx_d    = dec_idx;
               if (dec_hit) begin
                  state_d = StSetup;
               end else begin
                  state_d  = StResp;
                  code_d   = 2'b10;
                  rdata_d  = (|mem_wstrb_i) ? 32'h0 : ERR_RDATA;
                  err_done = 1'b1;
               end
            end
         end
         StSetup: begin
            tcnt_d  = '0;
            state_d = StAccess;
         end
         StAccess: begin
            if (sel_pready) begin
               state_d  = StResp;
               code_d   = sel_pslverr ? 2'b01 : 2'b00;
               err_done = sel_pslverr;
               if (pwrite_q)         rdata_d = 32'h0;
               else if (sel_pslverr) rdata_d = ERR_RDATA;
               else                  rdata_d = sel_prdata;
            end else if ((TIMEOUT_CYC != 0) && (tcnt_q == TIMEOUT_CYC - 1)) begin
               state_d  = StResp;
               code_d   = 2'b11;
               rdata_d  = pwrite_q ? 32'h0 : ERR_RDATA;
               err_done = 1'b1;
            end else begin
               tcnt_d = tcnt_q + 32'd1;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (err_done && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         pwrite_q <= 1'b0;
         idx_q    <= '0;
         rdata_q  <= '0;
         code_q   <= '0;
         cnt_q    <= '0;
         tcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         pwrite_q <= pwrite_d;
         idx_q    <= idx_d;
         rdata_q  <= rdata_d;
         code_q   <= code_d;
         cnt_q    <= cnt_d;
         tcnt_q   <= tcnt_d;
      end
   end

   assign mem_ready_o   = (state_q == StResp);
   assign mem_rdata_o   = mem_ready_o ? rdata_q : 32'h0;
   assign err_o         = mem_ready_o && (code_q != 2'b00);
   assign err_code_o    = code_q;
   assign err_cnt_o     = cnt_q;
   assign apb_paddr_o   = addr_q;
   assign apb_pprot_o   = 3'b000;
   assign apb_psel_o    = ((state_q == StSetup) || (state_q == StAccess)) ?
                          (NUM_SLV'(1) << idx_q) : '0;
   assign apb_penable_o = (state_q == StAccess);
   assign apb_pwrite_o  = pwrite_q;
   assign apb_pwdata_o  = wdata_q;
   assign apb_pstrb_o   = wstrb_q;

endmodule

// File: doc/nmi_apb_bridge.md
Name: nmi_apb_bridge

Overview:
Parametrised native-memory-interface (valid/ready) to APB4 bridge and decoder. It generalises the fixed-slave peripheral bridge: slave count and the address window of each slave are parameters, and read data arrives on a single flattened bus. It adds behaviour the fixed bridge lacks: decode-miss response, PREADY timeout, error reporting, and a saturating error counter. It sits between the CPU-side NMI port and the peripheral APB fabric.

Parameters:
NUM_SLV, 8, number of APB slaves (1..16)
SLV_BASE, {NUM_SLV{32'h0}}, packed NUM_SLV*32 vector; base address of slave i at [32*i+:32]
SLV_MASK, {NUM_SLV{32'hFFFF_F000}}, packed NUM_SLV*32 vector; decode mask of slave i
TIMEOUT_CYC, 256, maximum ACCESS cycles before abort; 0 disables the timeout
ERR_RDATA, 32'hDEAD_BEEF, mem_rdata_o value returned on any errored read
ERR_CNT_W, 8, width of the error counter

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
mem_valid_i  in  1  NMI request valid; held until mem_ready_o
mem_addr_i  in  32  NMI byte address
mem_wdata_i  in  32  NMI write data
mem_wstrb_i  in  4  NMI byte strobes; 0 means read
mem_rdata_o  out  32  NMI read data; valid while mem_ready_o=1
mem_ready_o  out  1  NMI completion, one-cycle pulse
apb_paddr_o  out  32  APB address (full address, not an offset)
apb_pprot_o  out  3  APB protection; constant 3'b000
apb_psel_o  out  NUM_SLV  one-hot slave select
apb_penable_o  out  1  APB enable
apb_pwrite_o  out  1  APB write
apb_pwdata_o  out  32  APB write data
apb_pstrb_o  out  4  APB strobes; 0 on reads
apb_pready_i  in  NUM_SLV  per-slave PREADY
apb_prdata_i  in  NUM_SLV*32  flattened PRDATA; slave i at [32*i+:32]
apb_pslverr_i  in  NUM_SLV  per-slave PSLVERR
err_o  out  1  error pulse, coincident with mem_ready_o
err_code_o  out  2  code of the last completed transaction: 00 ok, 01 slverr, 10 decode miss, 11 timeout
err_cnt_o  out  ERR_CNT_W  saturating count of errored transactions

Behaviour:
- Reset (rst_i sampled high at a clock edge): FSM goes to IDLE. All outputs are 0, including err_cnt_o, err_code_o and the timeout counter. A reset mid-transaction aborts it: psel and penable drop at that edge and no mem_ready_o is issued.
- Decode: slave i hits when (mem_addr_i & SLV_MASK[i]) == SLV_BASE[i]. If several slaves hit, the lowest index wins. If none hits, the result is a decode miss.
- FSM states:
  - IDLE: on mem_valid_i=1, register addr, wdata and wstrb. Set pwrite = |wstrb and latch the selected index. A hit goes to SETUP; a miss goes to RESP with code 10.
  - SETUP: psel[idx]=1, penable=0, exactly one cycle, then ACCESS.
  - ACCESS: psel[idx]=1, penable=1. On apb_pready_i[idx]=1, capture prdata[idx] and pslverr[idx], then go to RESP with code 01 if pslverr else 00. The timeout counter increments each ACCESS cycle without PREADY. With TIMEOUT_CYC>0, when the count reaches TIMEOUT_CYC-1 and PREADY is still low, go to RESP with code 11.
  - RESP: mem_ready_o=1 for one cycle. psel and penable are 0. Then IDLE. mem_valid_i is ignored in RESP; the master drops it after ready.
- Only the selected slave's pready/pslverr/prdata is observed; the others are don't-care.
- Latency: with a zero-wait slave, mem_valid_i rises at cycle 0 and mem_ready_o is high at cycle 3. Each PREADY wait state adds one cycle. A decode miss gives mem_ready_o at cycle 1.
- Read data: mem_rdata_o = captured prdata on ok reads, ERR_RDATA on any errored read, 0 on writes.
- APB outputs (paddr, pwrite, pwdata, pstrb) stay stable from SETUP through the end of ACCESS. They hold their last value in IDLE and RESP.
- Error reporting:
  - err_o = 1 in RESP iff code != 00.
  - err_code_o updates at entry to RESP and holds until the next completion.
  - err_cnt_o increments by 1 per errored completion and saturates at all-ones.
- Timeout abort: psel drops without a completed APB transfer. A late PREADY from that slave is ignored.

Test Plan:
- Zero-wait read, NUM_SLV=4, SLV_BASE[2]=0x1000_2000, mask 0xFFFF_F000: read 0x1000_2004 with slave 2 returning 0x1234_5678 -> psel=4'b0100 at cycles 1-2, penable at cycle 2, mem_ready_o at cycle 3 with rdata 0x1234_5678, err_code 00.
- Write with 3 wait states: wstrb=4'b0011, wdata 0xAABB_CCDD -> pwrite=1, pstrb=0011, pwdata stable through all 4 ACCESS cycles, mem_ready_o at cycle 6, rdata 0.
- Decode miss: read 0x2000_0000 -> no psel ever, mem_ready_o at cycle 1, rdata 0xDEAD_BEEF, err_o=1, err_code 10, err_cnt 0->1.
- Timeout: TIMEOUT_CYC=4, slave never ready -> penable for 4 cycles, then RESP with rdata 0xDEAD_BEEF, code 11; a later PREADY pulse does not produce a second ready.
- PSLVERR plus saturation: ERR_CNT_W=2, five slverr reads -> each gives code 01 and rdata 0xDEAD_BEEF; err_cnt_o goes 1,2,3,3,3.
- Reset in ACCESS: assert rst_i in the second wait cycle -> next edge psel=0, penable=0, mem_ready_o never asserts, err_cnt 0; a new request then completes normally.
